frame_diff_binarize: RTL and testbench

//  Frame-difference motion stage sitting directly upstream of the LCD dual-window driver.
//  - Consumes the current-frame grayscale pixel stream and the matching previous-frame pixel (DDR read FIFO).
//  - Computes |cur - prev|, thresholds it, and emits a 24-bit binary pixel (0x000000 / 0xFFFFFF) as driver lcd_data.
//  - Also publishes a per-frame count of motion pixels for host/debug readout.

---
 rtl/frame_diff_binarize_pkg.sv | 10 +
 rtl/frame_diff_binarize_abs_diff.sv | 30 +++
 rtl/frame_diff_binarize.sv | 114 +++++++++++
 tb/tb_frame_diff_binarize.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_diff_binarize_pkg.sv
// Shared widths, default threshold and binary pixel codes for the frame-difference motion stage.
package frame_diff_binarize_pkg;

    localparam int                GRAY_W     = 8;
    localparam int                MCNT_W     = 22;
    localparam logic [GRAY_W-1:0] TH_DEFAULT = 8'd32;
    localparam logic [23:0]       BIN_ON     = 24'hFFFFFF;
    localparam logic [23:0]       BIN_OFF    = 24'h000000;

endpackage

// File: rtl/frame_diff_binarize_abs_diff.sv
// Registered absolute difference of two unsigned pixels; forms pipeline stage S2.
module abs_diff #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          vld,
    output logic [DW-1:0] diff,
    output logic          diff_vld
);

    logic [DW-1:0] diff_c;

    // Subtracting the smaller operand from the larger one keeps the result in DW bits.
    always_comb diff_c = (a >= b) ? a - b : b - a;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff     <= '0;
            diff_vld <= 1'b0;
        end else begin
            diff     <= diff_c;
            diff_vld <= vld;
        end
    end

endmodule

// File: rtl/frame_diff_binarize.sv
// Frame-difference motion stage: |cur - prev| thresholded into a 24-bit binary pixel,
// with a saturating per-frame motion-pixel count and a sticky valid-mismatch flag.
module frame_diff_binarize
    import frame_diff_binarize_pkg::*;
#(
    parameter int            DW     = GRAY_W,
    parameter int            CNT_W  = MCNT_W,
    parameter logic [DW-1:0] TH_RST = TH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lcd_vs,
    input  logic [DW-1:0]    th_in,
    input  logic             cur_valid,
    input  logic [DW-1:0]    cur_gray,
    input  logic             prev_valid,
    input  logic [DW-1:0]    prev_gray,
    output logic             out_valid,
    output logic [23:0]      out_data,
    output logic [CNT_W-1:0] motion_cnt,
    output logic             motion_cnt_vld,
    output logic             sync_err
);

    logic             vs_d;
    logic             armed;
    logic             fs;
    logic [DW-1:0]    th_q;
    logic [DW-1:0]    a1;
    logic [DW-1:0]    b1;
    logic             v1;
    logic [DW-1:0]    d2;
    logic             v2;
    logic             hit3;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;

    // armed masks the first cycle after reset so a low lcd_vs there is not taken as a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b1;
            armed <= 1'b0;
            th_q  <= TH_RST;
        end else begin
            vs_d  <= lcd_vs;
            armed <= 1'b1;
            if (fs) th_q <= th_in;
        end
    end

    assign fs = armed & vs_d & ~lcd_vs;

    // S1: a side whose valid is low contributes 0, so a mismatched pixel still flows as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1 <= '0;
            b1 <= '0;
            v1 <= 1'b0;
        end else begin
            a1 <= cur_valid  ? cur_gray  : '0;
            b1 <= prev_valid ? prev_gray : '0;
            v1 <= cur_valid | prev_valid;
        end
    end

    abs_diff #(.DW(DW)) u_abs_diff (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a1),
        .b        (b1),
        .vld      (v1),
        .diff     (d2),
        .diff_vld (v2)
    );

    // S3: strict compare, d == th_q counts as no motion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= BIN_OFF;
            hit3      <= 1'b0;
        end else begin
            out_valid <= v2;
            out_data  <= (v2 && (d2 > th_q)) ? BIN_ON : BIN_OFF;
            hit3      <= v2 && (d2 > th_q);
        end
    end

    always_comb acc_inc = (hit3 && (acc != '1)) ? acc + CNT_W'(1) : acc;

    // The pixel leaving S3 on the fs cycle is counted into the frame being closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            motion_cnt     <= '0;
            motion_cnt_vld <= 1'b0;
        end else begin
            motion_cnt_vld <= fs;
            if (fs) begin
                motion_cnt <= acc_inc;
                acc        <= '0;
            end else begin
                acc        <= acc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       sync_err <= 1'b0;
        else if (cur_valid != prev_valid) sync_err <= 1'b1;
        else if (fs)                      sync_err <= 1'b0;
    end

endmodule

// File: tb/tb_frame_diff_binarize.sv
// Scoreboard bench for frame_diff_binarize: directed pixels with hand-derived results, plus a
// CNT_W=4 copy on the same stimulus to observe counter saturation.
module tb_frame_diff_binarize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lcd_vs = 1'b1;
    logic [7:0]  th_in = 8'd32;
    logic        cur_valid = 1'b0;
    logic [7:0]  cur_gray = '0;
    logic        prev_valid = 1'b0;
    logic [7:0]  prev_gray = '0;

    logic        out_valid;
    logic [23:0] out_data;
    logic [21:0] motion_cnt;
    logic        motion_cnt_vld;
    logic        sync_err;

    logic        s_out_valid;
    logic [23:0] s_out_data;
    logic [3:0]  s_motion_cnt;
    logic        s_motion_cnt_vld;
    logic        s_sync_err;

    int n_vec = 0;
    int n_err = 0;
    int frame_hits = 0;
    logic [23:0] pix_q[$];
    int          cnt_q[$];

    always #5 clk = ~clk;

    frame_diff_binarize dut (
        .clk(clk), .rst_n(rst_n), .lcd_vs(lcd_vs), .th_in(th_in),
        .cur_valid(cur_valid), .cur_gray(cur_gray),
        .prev_valid(prev_valid), .prev_gray(prev_gray),
        .out_valid(out_valid), .out_data(out_data),
        .motion_cnt(motion_cnt), .motion_cnt_vld(motion_cnt_vld), .sync_err(sync_err)
    );

    frame_diff_binarize #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .lcd_vs(lcd_vs), .th_in(th_in),
        .cur_valid(cur_valid), .cur_gray(cur_gray),
        .prev_valid(prev_valid), .prev_gray(prev_gray),
        .out_valid(s_out_valid), .out_data(s_out_data),
        .motion_cnt(s_motion_cnt), .motion_cnt_vld(s_motion_cnt_vld), .sync_err(s_sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] p, input logic cv, input logic pv,
                        input bit hit);
        cur_gray   = c;
        prev_gray  = p;
        cur_valid  = cv;
        prev_valid = pv;
        if (cv || pv) begin
            pix_q.push_back(hit ? 24'hFFFFFF : 24'h000000);
            if (hit) frame_hits++;
        end
        cyc();
    endtask

    task automatic idle(input int n);
        cur_valid  = 1'b0;
        prev_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (pix_q.size() == 0 && cnt_q.size() == 0) break;
            cyc();
        end
        check("drain_pix_pending", pix_q.size(), 0);
        check("drain_cnt_pending", cnt_q.size(), 0);
    endtask

    // Frame start with the pipeline drained, so the published count is exactly frame_hits.
    task automatic frame_start();
        idle(6);
        lcd_vs = 1'b0;
        cnt_q.push_back(frame_hits);
        frame_hits = 0;
        cyc();
        check("sync_err_after_fs", sync_err, 0);
        repeat (2) cyc();
        lcd_vs = 1'b1;
        cyc();
        drain();
    endtask

    // Monitor: pops expected pixels/counts whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (pix_q.size() == 0) check("unexpected_pixel", out_data, 32'hDEAD);
                else check("out_data", out_data, pix_q.pop_front());
            end else begin
                check("out_data_idle_zero", out_data, 0);
            end
            if (motion_cnt_vld) begin
                if (cnt_q.size() == 0) begin
                    check("unexpected_cnt_vld", motion_cnt_vld, 0);
                end else begin
                    int e;
                    e = cnt_q.pop_front();
                    check("motion_cnt", motion_cnt, e);
                    check("motion_cnt_sat4", s_motion_cnt, (e > 15) ? 15 : e);
                end
            end
            check("small_cnt_vld_align", s_motion_cnt_vld, motion_cnt_vld);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_motion_cnt", motion_cnt, 0);
        check("rst_motion_cnt_vld", motion_cnt_vld, 0);
        check("rst_sync_err", sync_err, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        idle(3);

        // First fs after reset: no pixels seen yet.
        frame_start();

        // T1: d=100 > 32, latency 3.
        send(8'd200, 8'd100, 1'b1, 1'b1, 1'b1);
        check("t1_lat1_valid", out_valid, 0);
        idle(1);
        check("t1_lat2_valid", out_valid, 0);
        idle(1);
        check("t1_lat3_valid", out_valid, 1);
        check("t1_lat3_data", out_data, 32'hFFFFFF);
        drain();

        // T2: d == th is no motion, both subtraction directions.
        send(8'd50, 8'd82, 1'b1, 1'b1, 1'b0);
        send(8'd50, 8'd83, 1'b1, 1'b1, 1'b1);
        send(8'd82, 8'd50, 1'b1, 1'b1, 1'b0);
        send(8'd83, 8'd50, 1'b1, 1'b1, 1'b1);
        frame_start();

        // T3: 1000 pixels, 137 with d=100, the rest d=0.
        for (int i = 0; i < 1000; i++) begin
            if (i < 137) send(8'd200, 8'd100, 1'b1, 1'b1, 1'b1);
            else         send(8'(i), 8'(i), 1'b1, 1'b1, 1'b0);
        end
        check("t3_frame_hits", frame_hits, 137);
        frame_start();

        // T4: mid-frame threshold change is ignored until the next fs.
        send(8'd200, 8'd0, 1'b1, 1'b1, 1'b1);
        th_in = 8'd250;
        send(8'd200, 8'd0, 1'b1, 1'b1, 1'b1);
        frame_start();
        send(8'd200, 8'd0, 1'b1, 1'b1, 1'b0);
        send(8'd255, 8'd4, 1'b1, 1'b1, 1'b1);
        send(8'd4, 8'd254, 1'b1, 1'b1, 1'b0);

        // T5: missing prev side reads as 0 (d=255 > 250); sync_err sticky until fs.
        check("t5_sync_err_before", sync_err, 0);
        send(8'd255, 8'd255, 1'b1, 1'b0, 1'b1);
        check("t5_sync_err_set", sync_err, 1);
        idle(4);
        check("t5_sync_err_sticky", sync_err, 1);
        th_in = 8'd32;
        frame_start();

        // Saturation frame: 20 motion pixels, the CNT_W=4 copy must report 15.
        for (int i = 0; i < 20; i++) send(8'd200, 8'd100, 1'b1, 1'b1, 1'b1);
        th_in = 8'd250;
        frame_start();

        // T6: async reset with pixels in flight; th_q returns to 32.
        send(8'd200, 8'd0, 1'b1, 1'b1, 1'b0);
        send(8'd10, 8'd10, 1'b1, 1'b0, 1'b0);
        send(8'd1, 8'd2, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_motion_cnt", motion_cnt, 0);
        check("t6_motion_cnt_vld", motion_cnt_vld, 0);
        check("t6_sync_err", sync_err, 0);
        pix_q.delete();
        frame_hits = 0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send(8'd66, 8'd33, 1'b1, 1'b1, 1'b1);
        frame_start();

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
